cordic_req_arbiter: RTL and testbench
=====================================

CORDIC_REQ_ARBITER -- requirements
Module: cordic_req_arbiter

Interface
REQ-001 Parameters (SHALL be honoured as given): NREQ, 4, number of requesters (2..8); XY_W, 16, x/y/result width; ANGLE_W, 32, angle width; DEPTH, 8, max outstanding core transactions (power of 2, 2..16).
REQ-002 The block SHALL expose exactly these ports, each listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accepted.
- req_x, req_y  in  NREQ*XY_W  packed signed operands, requester i at [i*XY_W +: XY_W].
- req_angle  in  NREQ*ANGLE_W  packed angles.
- core_in_valid  out  1  valid toward the shared CORDIC core.
- core_in_ready  in  1  core accepts input.
- core_x, core_y  out  XY_W  muxed operands.
- core_angle  out  ANGLE_W  muxed angle.
- core_out_valid  in  1  core result valid.
- core_out_ready  out  1  result consumed.
- core_cos, core_sin  in  XY_W  core results.
- resp_valid  out  NREQ  result valid, one-hot or zero.
- resp_ready  in  NREQ  per-requester result ready.
- resp_cos, resp_sin  out  XY_W  core_cos/core_sin passed through, shared by all requesters.
- outstanding  out  $clog2(DEPTH)+1  transactions in flight.
- err_orphan  out  1  sticky: core result arrived with no tag outstanding.

Function
REQ-003 Round-robin arbitration SHALL be used: priority starts at index rr_ptr+1 and wraps modulo NREQ; rr_ptr resets to NREQ-1, so requester 0 has first priority.
REQ-004 Grant selection (combinational) SHALL occur only when no grant is locked; the chosen index drives core_x/core_y/core_angle, and core_in_valid=1.
REQ-005 If core_in_valid=1 and core_in_ready=0, the grant SHALL lock; index and core_* data stay stable until the handshake, even if other requesters assert.
REQ-006 Core accept SHALL be the cycle core_in_valid & core_in_ready; req_ready[g]=1 in that cycle only, and all other req_ready=0.
REQ-007 On accept: push g into the tag FIFO, set rr_ptr=g, release the lock.
REQ-008 core_in_valid SHALL be forced to 0 while the tag FIFO is full (outstanding==DEPTH); the lock is not formed in that case.
REQ-009 The core is in-order. The tag FIFO head h SHALL route results: resp_valid[h]=core_out_valid & !empty; core_out_ready=resp_ready[h] & !empty.
REQ-010 On response handshake (core_out_valid & core_out_ready), pop the tag FIFO.
REQ-011 When the FIFO is empty: resp_valid=0 and core_out_ready=1, so an orphan result is drained. If core_out_valid=1, set err_orphan (it clears only on reset).
REQ-012 Simultaneous push and pop SHALL leave outstanding unchanged; pointers wrap modulo DEPTH.
REQ-013 Push while FIFO full SHALL be impossible (guaranteed by REQ-008). Pop while empty SHALL never occur.
REQ-014 Zero-latency path: a response handshake and a new grant SHALL be possible in the same cycle. If the FIFO was full, a pop frees a slot on the next cycle only (no combinational full-bypass).
REQ-015 Throughput: with the core always ready, the block SHALL sustain one accept per cycle.

Reset
REQ-016 On rst_n low, immediately: all outputs 0 except core_out_ready=1; rr_ptr=NREQ-1; lock clear; FIFO empty; outstanding=0; err_orphan=0.
REQ-017 Reset mid-transaction SHALL discard all tags. Any core result arriving after reset is treated as orphan per REQ-011; the core SHALL be reset by the same rst_n.

Verification
REQ-018 Reset release, req_valid=4'b1111, core always ready -> grants in order 0,1,2,3,0 on consecutive cycles; outstanding increments by 1 per cycle until the core returns results.
REQ-019 Requester 2 granted, core_in_ready=0 for 5 cycles while req 0 asserts -> core_x stays req 2 data for all 5 cycles; grant goes to 2, then 3/0 follows RR; req_ready[0] stays 0 throughout.
REQ-020 Core stalls outputs, 9 requests issued -> after 8 accepts, core_in_valid=0 and outstanding=8. One response popped -> the next accept occurs one cycle later.
REQ-021 Tags 1,3,1 in flight, resp_ready[3]=0 -> the second result is held with core_out_ready=0; the third result is not delivered to requester 1 until requester 3 accepts.
REQ-022 core_out_valid pulse with outstanding=0 -> err_orphan=1 next cycle and stays 1; resp_valid remains 0.
REQ-023 rst_n asserted with 3 outstanding -> outstanding=0, req_ready=0 and resp_valid=0 asynchronously.

Source files
------------

// File: rtl/cordic_req_arbiter.sv
// Round-robin front end sharing one in-order CORDIC core among NREQ requesters.
// A tag FIFO records the grant order so results route back to their requesters.
module cordic_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned XY_W    = 16,
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*XY_W-1:0]       req_x,
    input  logic [NREQ*XY_W-1:0]       req_y,
    input  logic [NREQ*ANGLE_W-1:0]    req_angle,
    output logic                       core_in_valid,
    input  logic                       core_in_ready,
    output logic [XY_W-1:0]            core_x,
    output logic [XY_W-1:0]            core_y,
    output logic [ANGLE_W-1:0]         core_angle,
    input  logic                       core_out_valid,
    output logic                       core_out_ready,
    input  logic [XY_W-1:0]            core_cos,
    input  logic [XY_W-1:0]            core_sin,
    output logic [NREQ-1:0]            resp_valid,
    input  logic [NREQ-1:0]            resp_ready,
    output logic [XY_W-1:0]            resp_cos,
    output logic [XY_W-1:0]            resp_sin,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_orphan
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned PW   = $clog2(DEPTH);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_e;

    lock_state_e       state_q, state_d;
    logic [IDXW-1:0]   lock_idx_q, lock_idx_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   tag_mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              err_orphan_q, err_orphan_d;

    logic              gnt_found;
    logic [IDXW-1:0]   gnt_idx;
    logic [IDXW-1:0]   cand;
    logic [IDXW-1:0]   head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;

    assign fifo_full  = (count_q == (PW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // A locked grant overrides the search so data stays stable across a core stall.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (state_q == ST_LOCKED) begin
            gnt_found = 1'b1;
            gnt_idx   = lock_idx_q;
        end else begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                cand = IDXW'((32'(rr_ptr_q) + i) % NREQ);
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // Reset gates the request side so outputs clear immediately on rst_n low.
    assign core_in_valid = rst_n & gnt_found & ~fifo_full;
    assign accept        = core_in_valid & core_in_ready;

    always_comb begin
        core_x     = '0;
        core_y     = '0;
        core_angle = '0;
        req_ready  = '0;
        if (core_in_valid) begin
            core_x     = req_x[32'(gnt_idx)*XY_W +: XY_W];
            core_y     = req_y[32'(gnt_idx)*XY_W +: XY_W];
            core_angle = req_angle[32'(gnt_idx)*ANGLE_W +: ANGLE_W];
        end
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            state_d  = ST_OPEN;
            rr_ptr_d = gnt_idx;
        end else if (core_in_valid) begin
            state_d    = ST_LOCKED;
            lock_idx_d = gnt_idx;
        end
    end

    // Empty FIFO drains any result as an orphan instead of stalling the core.
    always_comb begin
        resp_valid     = '0;
        core_out_ready = 1'b1;
        if (!fifo_empty) begin
            resp_valid[head] = core_out_valid;
            core_out_ready   = resp_ready[head];
        end
    end

    assign pop      = core_out_valid & core_out_ready & ~fifo_empty;
    assign resp_cos = rst_n ? core_cos : '0;
    assign resp_sin = rst_n ? core_sin : '0;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q | (core_out_valid & fifo_empty);
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OPEN;
            lock_idx_q   <= '0;
            rr_ptr_q     <= IDXW'(NREQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign outstanding = count_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter: arbitration order, grant lock,
// FIFO-full backpressure, in-order response routing, orphan and async reset.
module tb_cordic_req_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned XY_W    = 16;
    localparam int unsigned ANGLE_W = 32;
    localparam int unsigned DEPTH   = 8;

    logic                     clk;
    logic                     rst_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*XY_W-1:0]     req_x;
    logic [NREQ*XY_W-1:0]     req_y;
    logic [NREQ*ANGLE_W-1:0]  req_angle;
    logic                     core_in_valid;
    logic                     core_in_ready;
    logic [XY_W-1:0]          core_x;
    logic [XY_W-1:0]          core_y;
    logic [ANGLE_W-1:0]       core_angle;
    logic                     core_out_valid;
    logic                     core_out_ready;
    logic [XY_W-1:0]          core_cos;
    logic [XY_W-1:0]          core_sin;
    logic [NREQ-1:0]          resp_valid;
    logic [NREQ-1:0]          resp_ready;
    logic [XY_W-1:0]          resp_cos;
    logic [XY_W-1:0]          resp_sin;
    logic [$clog2(DEPTH):0]   outstanding;
    logic                     err_orphan;

    int checks;
    int errors;

    cordic_req_arbiter #(
        .NREQ    (NREQ),
        .XY_W    (XY_W),
        .ANGLE_W (ANGLE_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_x          (req_x),
        .req_y          (req_y),
        .req_angle      (req_angle),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_x         (core_x),
        .core_y         (core_y),
        .core_angle     (core_angle),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .core_cos       (core_cos),
        .core_sin       (core_sin),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_cos       (resp_cos),
        .resp_sin       (resp_sin),
        .outstanding    (outstanding),
        .err_orphan     (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned tags_a [5];
        int unsigned tags_b [3];
        tags_a = '{0, 1, 2, 3, 0};
        tags_b = '{2, 3, 0};
        checks = 0;
        errors = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*XY_W +: XY_W]           = 16'h1000 + 16'(i);
            req_y[i*XY_W +: XY_W]           = 16'h2000 + 16'(i);
            req_angle[i*ANGLE_W +: ANGLE_W] = 32'hA000_0000 + 32'(i);
        end
        rst_n          = 1'b0;
        req_valid      = 4'b1111;
        core_in_ready  = 1'b1;
        core_out_valid = 1'b0;
        resp_ready     = '0;
        core_cos       = 16'h0C05;
        core_sin       = 16'h05A1;

        // Reset state while requests are already pending
        #12;
        check("rst_in_valid", 32'(core_in_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_ready", 32'(core_out_ready), 32'd1);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err_orphan", 32'(err_orphan), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_core_x", 32'(core_x), 32'd0);

        // All requesters active, core always ready: grants 0,1,2,3,0
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_req_ready", 32'(req_ready), 32'(1) << (k % 4));
            check("rr_core_x", 32'(core_x), 32'h1000 + 32'(k % 4));
            check("rr_core_angle", core_angle, 32'hA000_0000 + 32'(k % 4));
            check("rr_outstanding", 32'(outstanding), 32'(k));
            next_cycle();
        end
        req_valid      = '0;
        core_out_valid = 1'b1;
        resp_ready     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("drain_resp_valid", 32'(resp_valid), 32'(1) << tags_a[k]);
            check("drain_out_ready", 32'(core_out_ready), 32'd1);
            check("drain_outstanding", 32'(outstanding), 32'(5 - k));
            next_cycle();
        end
        check("resp_cos_pass", 32'(resp_cos), 32'h0C05);
        check("resp_sin_pass", 32'(resp_sin), 32'h05A1);
        core_out_valid = 1'b0;
        @(negedge clk);
        check("drained_outstanding", 32'(outstanding), 32'd0);

        // Grant to 2 locks through a 5-cycle core stall while requester 0 asserts
        next_cycle();
        req_valid     = 4'b0100;
        core_in_ready = 1'b0;
        @(negedge clk);
        check("lock_in_valid", 32'(core_in_valid), 32'd1);
        check("lock_first_x", 32'(core_x), 32'h1002);
        next_cycle();
        req_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("lock_core_x", 32'(core_x), 32'h1002);
            check("lock_core_y", 32'(core_y), 32'h2002);
            check("lock_req_ready", 32'(req_ready), 32'd0);
            next_cycle();
        end
        core_in_ready = 1'b1;
        @(negedge clk);
        check("lock_release", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = 4'b1001;
        @(negedge clk);
        check("after_lock_3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = 4'b0001;
        @(negedge clk);
        check("after_lock_0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid      = '0;
        core_out_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lock_drain_resp", 32'(resp_valid), 32'(1) << tags_b[k]);
            next_cycle();
        end
        core_out_valid = 1'b0;

        // Fill the tag FIFO with requester 1, then free one slot
        req_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fill_req_ready", 32'(req_ready), 32'b0010);
            check("fill_outstanding", 32'(outstanding), 32'(k));
            next_cycle();
        end
        @(negedge clk);
        check("full_in_valid", 32'(core_in_valid), 32'd0);
        check("full_outstanding", 32'(outstanding), 32'd8);
        check("full_req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        core_out_valid = 1'b1;
        resp_ready     = 4'b0010;
        @(negedge clk);
        check("full_pop_in_valid", 32'(core_in_valid), 32'd0);
        check("full_pop_resp", 32'(resp_valid), 32'b0010);
        check("full_pop_out_ready", 32'(core_out_ready), 32'd1);
        next_cycle();
        core_out_valid = 1'b0;
        @(negedge clk);
        check("refill_outstanding", 32'(outstanding), 32'd7);
        check("refill_req_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid      = '0;
        core_out_valid = 1'b1;
        resp_ready     = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("full_drain_resp", 32'(resp_valid), 32'b0010);
            next_cycle();
        end
        core_out_valid = 1'b0;
        @(negedge clk);
        check("full_drained", 32'(outstanding), 32'd0);

        // Tags 1,3,1 in flight; requester 3 holds off its result
        next_cycle();
        req_valid = 4'b0010;
        next_cycle();
        req_valid = 4'b1000;
        next_cycle();
        req_valid = 4'b0010;
        next_cycle();
        req_valid      = '0;
        core_out_valid = 1'b1;
        resp_ready     = 4'b0010;
        @(negedge clk);
        check("hol_outstanding", 32'(outstanding), 32'd3);
        check("hol_first_resp", 32'(resp_valid), 32'b0010);
        check("hol_first_ready", 32'(core_out_ready), 32'd1);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hol_held_resp", 32'(resp_valid), 32'b1000);
            check("hol_held_ready", 32'(core_out_ready), 32'd0);
            check("hol_held_outstanding", 32'(outstanding), 32'd2);
            next_cycle();
        end
        resp_ready = 4'b1010;
        @(negedge clk);
        check("hol_second_ready", 32'(core_out_ready), 32'd1);
        next_cycle();
        @(negedge clk);
        check("hol_third_resp", 32'(resp_valid), 32'b0010);
        next_cycle();
        core_out_valid = 1'b0;
        @(negedge clk);
        check("hol_drained", 32'(outstanding), 32'd0);

        // Orphan result with nothing outstanding
        next_cycle();
        core_out_valid = 1'b1;
        resp_ready     = '0;
        @(negedge clk);
        check("orphan_resp_valid", 32'(resp_valid), 32'd0);
        check("orphan_out_ready", 32'(core_out_ready), 32'd1);
        check("orphan_not_yet", 32'(err_orphan), 32'd0);
        next_cycle();
        core_out_valid = 1'b0;
        @(negedge clk);
        check("orphan_set", 32'(err_orphan), 32'd1);
        next_cycle();
        @(negedge clk);
        check("orphan_sticky", 32'(err_orphan), 32'd1);

        // Three outstanding (2,3,0), then asynchronous reset mid-cycle
        next_cycle();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
        end
        core_out_valid = 1'b1;
        @(negedge clk);
        check("pre_rst_outstanding", 32'(outstanding), 32'd3);
        check("pre_rst_resp", 32'(resp_valid), 32'b0100);
        check("pre_rst_req_ready", 32'(req_ready), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_outstanding", 32'(outstanding), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        check("async_resp_valid", 32'(resp_valid), 32'd0);
        check("async_in_valid", 32'(core_in_valid), 32'd0);
        check("async_out_ready", 32'(core_out_ready), 32'd1);
        check("async_err_orphan", 32'(err_orphan), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
